// File: rtl/vgm_apb_pkg.sv
// Shared types and widths for the APB master arbiter slice.
package vgm_apb_pkg;
  localparam int VGM_APB_ADDR_W = 32;
  localparam int VGM_APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } vgm_apb_state_e;
endpackage

// File: rtl/vgm_apb_rr_arbiter.sv
// Round-robin requester select; search starts one past the last accepted grant.
module vgm_apb_rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REQ-1:0]         req_i,
  input  logic                     accept_i,
  output logic [N_REQ-1:0]         grant_o,
  output logic [$clog2(N_REQ)-1:0] grant_idx_o,
  output logic                     any_o
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] last_q;

  always_comb begin
    int cand;
    grant_idx_o = last_q;
    any_o       = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        grant_idx_o = cand[IDX_W-1:0];
      end
    end
    grant_o = '0;
    if (any_o) grant_o[grant_idx_o] = 1'b1;
  end

  // Reset value makes requester 0 the first winner.
  always_ff @(posedge clk_i) begin
    if (rst_i) last_q <= IDX_W'(N_REQ - 1);
    else if (accept_i && any_o) last_q <= grant_idx_o;
  end
endmodule

// File: rtl/vgm_apb_master_arbiter.sv
// Shares one APB master port among N_REQ requesters with one transfer in flight.
// Optional ACCESS-phase timeout abort is enabled by defining VGM_APB_ARB_TIMEOUT_EN.
module vgm_apb_master_arbiter
  import vgm_apb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                             PCLK,
  input  logic                             PRESET,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ*VGM_APB_ADDR_W-1:0]  req_addr,
  input  logic [N_REQ-1:0]                 req_write,
  input  logic [N_REQ*VGM_APB_DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]                 req_ready,
  output logic [N_REQ-1:0]                 rsp_valid,
  output logic [VGM_APB_DATA_W-1:0]        rsp_rdata,
  output logic                             rsp_err,
  output logic                             PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [VGM_APB_ADDR_W-1:0]        PADDR,
  output logic [VGM_APB_DATA_W-1:0]        PWDATA,
  input  logic                             PREADY,
  input  logic [VGM_APB_DATA_W-1:0]        PRDATA,
  output vgm_apb_state_e                   dbg_state
);
  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("vgm_apb_master_arbiter: N_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  vgm_apb_state_e              state_q, state_d;
  logic                        psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [VGM_APB_ADDR_W-1:0]   paddr_q, paddr_d;
  logic [VGM_APB_DATA_W-1:0]   pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [IDX_W-1:0]            idx_q, idx_d, g_idx;
  logic [N_REQ-1:0]            rsp_valid_q, rsp_valid_d, grant;
  logic                        rsp_err_q, rsp_err_d, any_req, accept;

  // Handshake: request i is taken in the cycle where req_valid[i] && req_ready[i];
  // req_ready is only raised at IDLE or at an ACCESS cycle that sees PREADY.
  assign accept    = any_req && ((state_q == IDLE) || (state_q == ACCESS && PREADY));
  assign req_ready = accept ? grant : '0;

  vgm_apb_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk_i       (PCLK),
    .rst_i       (PRESET),
    .req_i       (req_valid),
    .accept_i    (accept),
    .grant_o     (grant),
    .grant_idx_o (g_idx),
    .any_o       (any_req)
  );

`ifdef VGM_APB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_hit;

  // Counter sits at zero outside ACCESS, so every ACCESS entry starts fresh.
  assign tmo_hit = (state_q == ACCESS) && !PREADY && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET || state_q != ACCESS) tmo_q <= '0;
    else if (!PREADY)                tmo_q <= tmo_q + 1'b1;
  end
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    idx_d       = idx_q;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_valid_d[idx_q] = 1'b1;
          rsp_rdata_d        = pwrite_q ? '0 : PRDATA;
          state_d            = IDLE;
          psel_d             = 1'b0;
          penable_d          = 1'b0;
        end
`ifdef VGM_APB_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          rsp_valid_d[idx_q] = 1'b1;
          rsp_err_d          = 1'b1;
          state_d            = IDLE;
          psel_d             = 1'b0;
          penable_d          = 1'b0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    // A new accept overrides the return to IDLE, giving back-to-back SETUP.
    if (accept) begin
      state_d   = SETUP;
      psel_d    = 1'b1;
      penable_d = 1'b0;
      pwrite_d  = req_write[g_idx];
      paddr_d   = req_addr[g_idx*VGM_APB_ADDR_W +: VGM_APB_ADDR_W];
      pwdata_d  = req_wdata[g_idx*VGM_APB_DATA_W +: VGM_APB_DATA_W];
      idx_d     = g_idx;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      idx_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_vgm_apb_master_arbiter.sv
// Directed bench for vgm_apb_master_arbiter; timeout scenario runs when VGM_APB_ARB_TIMEOUT_EN is defined.
module tb_vgm_apb_master_arbiter;
  import vgm_apb_pkg::*;

  localparam int N = 2;
`ifdef VGM_APB_ARB_TIMEOUT_EN
  localparam int N_WAIT = 3;
`else
  localparam int N_WAIT = 5;
`endif

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*32-1:0] req_addr, req_wdata;
  logic [31:0]     rsp_rdata, PADDR, PWDATA, PRDATA;
  logic            rsp_err, PSEL, PENABLE, PWRITE, PREADY;
  vgm_apb_state_e  dbg_state;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  vgm_apb_master_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .dbg_state(dbg_state)
  );

  task automatic apply_reset();
    PRESET = 1'b1; req_valid = '0; PREADY = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PREADY = 1'b0; PRDATA = '0;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    checks++;
    if ({PADDR, PWDATA, PWRITE, rsp_rdata, rsp_err} !== '0) begin
      errors++; $display("FAIL rst_regs got addr=%h wdata=%h pwrite=%b rdata=%h err=%b exp all 0",
                         PADDR, PWDATA, PWRITE, rsp_rdata, rsp_err);
    end
    checks++;
    if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state got %0d exp %0d", dbg_state, IDLE); end
    for (int i = 0; i < 20; i++) begin
      @(negedge PCLK); #1;
      checks++;
      if ({PSEL, PENABLE, req_ready, rsp_valid} !== '0) begin
        errors++; $display("FAIL rst_idle_c%0d got psel=%b pen=%b rdy=%b rsp=%b exp 0", i, PSEL, PENABLE, req_ready, rsp_valid);
      end
    end
  endtask

  task automatic test_single_write();
    req_valid = 2'b01; req_write = 2'b01; req_addr[31:0] = 32'h10; req_wdata[31:0] = 32'hDEADBEEF; PREADY = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL wr_ready_c0 got %b exp 01", req_ready); end
    @(negedge PCLK);
    req_valid = '0; #1;
    checks++;
    if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA} !== {1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF}) begin
      errors++; $display("FAIL wr_setup_c1 got psel=%b pen=%b w=%b a=%h d=%h exp 1 0 1 10 deadbeef", PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    checks++;
    if ((rsp_valid | req_ready) !== '0) begin errors++; $display("FAIL wr_quiet_c1 got rsp=%b rdy=%b exp 00", rsp_valid, req_ready); end
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, rsp_valid} !== 4'b1100) begin errors++; $display("FAIL wr_access_c2 got psel=%b pen=%b rsp=%b exp 1 1 00", PSEL, PENABLE, rsp_valid); end
    @(negedge PCLK);
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err} !== {2'b01, 32'h0, 1'b0}) begin
      errors++; $display("FAIL wr_rsp_c3 got v=%b d=%h e=%b exp 01 0 0", rsp_valid, rsp_rdata, rsp_err);
    end
    checks++;
    if ({PSEL, PENABLE} !== 2'b00) begin errors++; $display("FAIL wr_idle_c3 got psel=%b pen=%b exp 00", PSEL, PENABLE); end
    @(negedge PCLK);
    checks++;
    if (rsp_valid !== 2'b00) begin errors++; $display("FAIL wr_rsp_one_cycle got %b exp 00", rsp_valid); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_addr, prev_data;
    int g, pg;
    apply_reset();
    req_valid = 2'b11; req_write = 2'b00; req_addr = {32'h200, 32'h100}; PREADY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      g = k % 2; pg = (k + 1) % 2;
      prev_data = (pg == 0) ? 32'h1234 : 32'h5678;
      if (k > 0) begin
        checks++;
        if (PENABLE !== 1'b1) begin errors++; $display("FAIL rr_access_k%0d got pen=%b exp 1", k, PENABLE); end
      end
      PRDATA = prev_data; #1;
      checks++;
      if (req_ready !== (2'b01 << g)) begin errors++; $display("FAIL rr_grant_k%0d got %b exp %b", k, req_ready, 2'b01 << g); end
      @(negedge PCLK);
      exp_addr = (g == 0) ? 32'h100 : 32'h200;
      checks++;
      if ({PSEL, PENABLE, PADDR} !== {1'b1, 1'b0, exp_addr}) begin
        errors++; $display("FAIL rr_setup_k%0d got psel=%b pen=%b a=%h exp 1 0 %h", k, PSEL, PENABLE, PADDR, exp_addr);
      end
      if (k > 0) begin
        checks++;
        if ({rsp_valid, rsp_rdata} !== {2'b01 << pg, prev_data}) begin
          errors++; $display("FAIL rr_rsp_k%0d got v=%b d=%h exp %b %h", k, rsp_valid, rsp_rdata, 2'b01 << pg, prev_data);
        end
      end
      @(negedge PCLK);
    end
    PRDATA = 32'h5678; req_valid = '0; #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL rr_nogrant got %b exp 00", req_ready); end
    @(negedge PCLK);
    checks++;
    if ({rsp_valid, rsp_rdata, PSEL, PENABLE} !== {2'b10, 32'h5678, 2'b00}) begin
      errors++; $display("FAIL rr_last_rsp got v=%b d=%h psel=%b pen=%b exp 10 5678 0 0", rsp_valid, rsp_rdata, PSEL, PENABLE);
    end
  endtask

  task automatic test_wait_states();
    req_valid = 2'b01; req_write = 2'b01; req_addr[31:0] = 32'h40; req_wdata[31:0] = 32'hA5A50001;
    PREADY = 1'b0; PRDATA = 32'h77; #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL ws_ready got %b exp 01", req_ready); end
    @(negedge PCLK);
    req_valid = '0;
    @(negedge PCLK);
    for (int i = 0; i <= N_WAIT; i++) begin
      checks++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid} !== {3'b111, 32'h40, 32'hA5A50001, 2'b00}) begin
        errors++; $display("FAIL ws_hold_i%0d got psel=%b pen=%b w=%b a=%h d=%h rsp=%b", i, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid);
      end
      checks++;
      if (dbg_state !== ACCESS) begin errors++; $display("FAIL ws_state_i%0d got %0d exp %0d", i, dbg_state, ACCESS); end
      PREADY = (i == N_WAIT);
      @(negedge PCLK);
    end
    PREADY = 1'b0;
    checks++;
    if ({rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE} !== {2'b01, 32'h0, 3'b000}) begin
      errors++; $display("FAIL ws_rsp got v=%b d=%h e=%b psel=%b pen=%b exp 01 0 0 0 0", rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE);
    end
  endtask

  task automatic test_back_to_back_single();
    req_valid = 2'b10; req_write = 2'b00; req_addr[63:32] = 32'h300; PREADY = 1'b1; PRDATA = 32'hCAFE0001; #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL single_grant0 got %b exp 10", req_ready); end
    repeat (2) @(negedge PCLK);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL single_wrap_grant got %b exp 10", req_ready); end
    @(negedge PCLK);
    checks++;
    if ({rsp_valid, rsp_rdata, PSEL, PENABLE} !== {2'b10, 32'hCAFE0001, 2'b10}) begin
      errors++; $display("FAIL single_rsp0 got v=%b d=%h psel=%b pen=%b exp 10 cafe0001 1 0", rsp_valid, rsp_rdata, PSEL, PENABLE);
    end
    @(negedge PCLK);
    req_valid = '0; #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL single_nogrant got %b exp 00", req_ready); end
    @(negedge PCLK);
    checks++;
    if ({rsp_valid, PSEL} !== 3'b100) begin errors++; $display("FAIL single_rsp1 got v=%b psel=%b exp 10 0", rsp_valid, PSEL); end
  endtask

  task automatic test_reset_mid_transfer();
    req_valid = 2'b10; req_write = 2'b10; req_addr[63:32] = 32'h500; req_wdata[63:32] = 32'h1111; PREADY = 1'b0; #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL rmid_grant got %b exp 10", req_ready); end
    @(negedge PCLK);
    req_valid = '0;
    @(negedge PCLK);
    checks++;
    if (PENABLE !== 1'b1) begin errors++; $display("FAIL rmid_access got pen=%b exp 1", PENABLE); end
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    checks++;
    if ({PSEL, PENABLE, PADDR, rsp_valid} !== '0) begin
      errors++; $display("FAIL rmid_cleared got psel=%b pen=%b a=%h rsp=%b exp 0", PSEL, PENABLE, PADDR, rsp_valid);
    end
    @(negedge PCLK);
    checks++;
    if ({rsp_valid, PSEL} !== 3'b000) begin errors++; $display("FAIL rmid_norsp got v=%b psel=%b exp 00 0", rsp_valid, PSEL); end
    req_valid = 2'b11; #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_next_grant got %b exp 01", req_ready); end
    req_valid = '0;
  endtask

`ifdef VGM_APB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    req_valid = 2'b01; req_write = 2'b00; req_addr[31:0] = 32'h80; PRDATA = 32'hFFFF0000; PREADY = 1'b0; #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL tmo_grant got %b exp 01", req_ready); end
    @(negedge PCLK);
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      checks++;
      if ({PSEL, PENABLE, rsp_valid} !== 4'b1100) begin
        errors++; $display("FAIL tmo_wait_i%0d got psel=%b pen=%b rsp=%b exp 1 1 00", i, PSEL, PENABLE, rsp_valid);
      end
    end
    req_valid = 2'b10; #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL tmo_no_b2b got %b exp 00", req_ready); end
    @(negedge PCLK);
    req_valid = '0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE} !== {2'b01, 1'b1, 32'h0, 2'b00}) begin
      errors++; $display("FAIL tmo_abort got v=%b e=%b d=%h psel=%b pen=%b exp 01 1 0 0 0", rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_wait_states();
    test_back_to_back_single();
    test_reset_mid_transfer();
`ifdef VGM_APB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    @(negedge PCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
